// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register: STAGES chained main+skid slots with valid/ready.
// Bubbles leave the low CTRL_W payload bits at zero so they never write state.
module pipe_stage_elastic #(
  parameter int DATA_W = 71,
  parameter int CTRL_W = 2,
  parameter int STAGES = 1,
  parameter int OCC_W  = $clog2(2*STAGES+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [OCC_W-1:0]  occupancy
);

  localparam logic [DATA_W-1:0] CMASK =
    {DATA_W{1'b1}} >> (DATA_W - CTRL_W);

  logic [STAGES-1:0] m_valid_q, m_valid_d;
  logic [STAGES-1:0] s_valid_q, s_valid_d;
  logic [DATA_W-1:0] m_data_q [STAGES];
  logic [DATA_W-1:0] m_data_d [STAGES];
  logic [DATA_W-1:0] s_data_q [STAGES];
  logic [DATA_W-1:0] s_data_d [STAGES];
  logic [OCC_W-1:0]  occ_q, occ_d;

  logic [STAGES-1:0] up_valid;
  logic [STAGES-1:0] dn_ready;
  logic [STAGES-1:0] acc;
  logic [STAGES-1:0] pop;
  logic [DATA_W-1:0] up_data [STAGES];

  for (genvar g = 0; g < STAGES; g++) begin : g_link
    if (g == 0) begin : g_first
      assign up_valid[g] = in_valid;
      assign up_data[g]  = in_data;
    end else begin : g_mid
      assign up_valid[g] = m_valid_q[g-1];
      assign up_data[g]  = m_data_q[g-1];
    end
    if (g == STAGES-1) begin : g_last
      assign dn_ready[g] = out_ready;
    end else begin : g_inner
      assign dn_ready[g] = ~s_valid_q[g+1];
    end
    assign acc[g] = up_valid[g] & ~s_valid_q[g];
    assign pop[g] = m_valid_q[g] & dn_ready[g];
  end

  always_comb begin
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    m_data_d  = m_data_q;
    s_data_d  = s_data_q;
    for (int i = 0; i < STAGES; i++) begin
      if (!m_valid_q[i] || pop[i]) begin
        if (s_valid_q[i]) begin
          m_data_d[i]  = s_data_q[i];
          m_valid_d[i] = 1'b1;
          s_valid_d[i] = 1'b0;
        end else if (acc[i]) begin
          m_data_d[i]  = up_data[i];
          m_valid_d[i] = 1'b1;
        end else begin
          m_valid_d[i] = 1'b0;
        end
      end else if (acc[i]) begin
        s_data_d[i]  = up_data[i];
        s_valid_d[i] = 1'b1;
      end
    end
    occ_d = occ_q + OCC_W'(acc[0]) - OCC_W'(pop[STAGES-1]);
    // flush drops the concurrent input but still lets the head be consumed
    if (flush) begin
      m_valid_d = '0;
      s_valid_d = '0;
      occ_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= '0;
      s_valid_q <= '0;
      occ_q     <= '0;
      m_data_q  <= '{default: '0};
      s_data_q  <= '{default: '0};
    end else begin
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      occ_q     <= occ_d;
      m_data_q  <= m_data_d;
      s_data_q  <= s_data_d;
    end
  end

  assign in_ready  = ~s_valid_q[0];
  assign out_valid = m_valid_q[STAGES-1];
  assign out_data  = m_data_q[STAGES-1] & ~(CMASK & {DATA_W{~out_valid}});
  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: three instances (STAGES=1,2,3) on one clock,
// scoreboard queue of accepted payloads compared on each downstream pop.
module tb_pipe_stage_elastic;
  localparam int DW = 71;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          fl   [3];
  logic          iv   [3];
  logic [DW-1:0] id   [3];
  logic          ir   [3];
  logic          ov   [3];
  logic [DW-1:0] od   [3];
  logic          ordy [3];
  logic [1:0]    occ0;
  logic [2:0]    occ1;
  logic [2:0]    occ2;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] sb[$];
  int sbc[$];

  pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .STAGES(1)) u_s1 (
    .clk(clk), .rst(rst), .flush(fl[0]),
    .in_valid(iv[0]), .in_data(id[0]), .in_ready(ir[0]),
    .out_valid(ov[0]), .out_data(od[0]), .out_ready(ordy[0]),
    .occupancy(occ0));

  pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .STAGES(2)) u_s2 (
    .clk(clk), .rst(rst), .flush(fl[1]),
    .in_valid(iv[1]), .in_data(id[1]), .in_ready(ir[1]),
    .out_valid(ov[1]), .out_data(od[1]), .out_ready(ordy[1]),
    .occupancy(occ1));

  pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .STAGES(3)) u_s3 (
    .clk(clk), .rst(rst), .flush(fl[2]),
    .in_valid(iv[2]), .in_data(id[2]), .in_ready(ir[2]),
    .out_valid(ov[2]), .out_data(od[2]), .out_ready(ordy[2]),
    .occupancy(occ2));

  function automatic int occ_of(input int d);
    case (d)
      0:       return int'(occ0);
      1:       return int'(occ1);
      default: return int'(occ2);
    endcase
  endfunction

  function automatic logic [DW-1:0] rnd_pay(input int tag);
    return {32'(tag), 32'($urandom), 7'($urandom)};
  endfunction

  task automatic idle_inputs();
    for (int d = 0; d < 3; d++) begin
      fl[d] = 1'b0; iv[d] = 1'b0; id[d] = '0; ordy[d] = 1'b0;
    end
  endtask

  // handshakes seen before the edge, then advance to edge+1
  task automatic step(input int d, output bit a, output bit p);
    a = iv[d] && ir[d] && !fl[d];
    p = ov[d] && ordy[d];
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    sbc.delete();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++; if (ir[d] !== 1'b1) begin errors++;
        $display("FAIL reset_in_ready d%0d got %b want 1", d, ir[d]); end
      checks++; if (ov[d] !== 1'b0) begin errors++;
        $display("FAIL reset_out_valid d%0d got %b want 0", d, ov[d]); end
      checks++; if (od[d] !== '0) begin errors++;
        $display("FAIL reset_out_data d%0d got %h want 0", d, od[d]); end
      checks++; if (occ_of(d) != 0) begin errors++;
        $display("FAIL reset_occ d%0d got %0d want 0", d, occ_of(d)); end
    end
    rst = 1'b0;
    // load all-ones payloads, then reset together with flush
    for (int d = 0; d < 3; d++) begin iv[d] = 1'b1; id[d] = '1; end
    repeat (4) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) fl[d] = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++; if (ir[d] !== 1'b1) begin errors++;
        $display("FAIL rerst_in_ready d%0d got %b want 1", d, ir[d]); end
      checks++; if (ov[d] !== 1'b0) begin errors++;
        $display("FAIL rerst_out_valid d%0d got %b want 0", d, ov[d]); end
      checks++; if (od[d] !== '0) begin errors++;
        $display("FAIL rerst_out_data d%0d got %h want 0", d, od[d]); end
      checks++; if (occ_of(d) != 0) begin errors++;
        $display("FAIL rerst_occ d%0d got %0d want 0", d, occ_of(d)); end
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  task automatic test_stream();
    bit a, p;
    int n = 0;
    int got = 0;
    do_reset();
    ordy[1] = 1'b1;
    for (int c = 0; c < 20 && got < 8; c++) begin
      iv[1] = (n < 8);
      id[1] = DW'(n + 1);
      checks++;
      if (occ_of(1) > 2 || occ_of(1) != sb.size()) begin errors++;
        $display("FAIL stream_occ c%0d got %0d want %0d (<=2)", c, occ_of(1), sb.size()); end
      if (ov[1]) begin
        checks++;
        if (sb.size() == 0) begin errors++;
          $display("FAIL stream_spurious got %h want none", od[1]); end
        else if (od[1] !== sb[0] || c - sbc[0] != 2) begin errors++;
          $display("FAIL stream_data got %h lat %0d want %h lat 2", od[1], c - sbc[0], sb[0]); end
      end
      step(1, a, p);
      if (p) begin
        got++;
        if (sb.size() > 0) begin void'(sb.pop_front()); void'(sbc.pop_front()); end
      end
      if (a) begin sb.push_back(id[1]); sbc.push_back(c); n++; end
    end
    checks++; if (got != 8) begin errors++;
      $display("FAIL stream_count got %0d want 8", got); end
    idle_inputs();
  endtask

  task automatic test_stall();
    bit a, p;
    logic [DW-1:0] pend[$];
    logic [DW-1:0] pa;
    int a_pop = -1;
    int c_acc = -1;
    int npop = 0;
    do_reset();
    for (int k = 0; k < 3; k++) pend.push_back(rnd_pay(k + 1));
    pa = pend[0];
    for (int c = 0; c < 12; c++) begin
      ordy[0] = (c >= 4);
      iv[0] = (pend.size() > 0);
      if (pend.size() > 0) id[0] = pend[0]; else id[0] = '0;
      if (c == 2) begin
        checks++; if (ir[0] !== 1'b0) begin errors++;
          $display("FAIL stall_in_ready got %b want 0", ir[0]); end
        checks++; if (occ_of(0) != 2) begin errors++;
          $display("FAIL stall_occ got %0d want 2", occ_of(0)); end
      end
      if (c == 3) begin
        checks++; if (ov[0] !== 1'b1 || od[0] !== pa) begin errors++;
          $display("FAIL stall_hold got %b/%h want 1/%h", ov[0], od[0], pa); end
      end
      if (ov[0] && ordy[0]) begin
        checks++;
        if (sb.size() == 0 || od[0] !== sb[0]) begin errors++;
          $display("FAIL stall_order got %h want %h", od[0], sb.size() ? sb[0] : '0); end
        if (npop == 0) a_pop = c;
      end
      step(0, a, p);
      if (p) begin npop++; if (sb.size() > 0) void'(sb.pop_front()); end
      if (a) begin
        if (pend.size() == 1) c_acc = c;
        sb.push_back(pend.pop_front());
      end
    end
    checks++; if (npop != 3) begin errors++;
      $display("FAIL stall_count got %0d want 3", npop); end
    checks++; if (c_acc != a_pop + 1) begin errors++;
      $display("FAIL stall_c_accept got %0d want %0d", c_acc, a_pop + 1); end
    idle_inputs();
  endtask

  task automatic test_flush();
    bit a, p;
    logic [DW-1:0] pg;
    int seen = 0;
    do_reset();
    for (int c = 0; c < 10 && occ_of(1) < 4; c++) begin
      iv[1] = 1'b1;
      id[1] = rnd_pay(100 + c);
      step(1, a, p);
      if (a) sb.push_back(id[1]);
    end
    checks++; if (occ_of(1) != 4) begin errors++;
      $display("FAIL flush_fill got %0d want 4", occ_of(1)); end
    checks++; if (ir[1] !== 1'b0) begin errors++;
      $display("FAIL flush_full_ready got %b want 0", ir[1]); end
    fl[1] = 1'b1; iv[1] = 1'b1; id[1] = rnd_pay(999); ordy[1] = 1'b1;
    checks++; if (ov[1] !== 1'b1 || od[1] !== sb[0]) begin errors++;
      $display("FAIL flush_head got %b/%h want 1/%h", ov[1], od[1], sb[0]); end
    step(1, a, p);
    sb.delete();
    fl[1] = 1'b0; iv[1] = 1'b0;
    checks++; if (ov[1] !== 1'b0) begin errors++;
      $display("FAIL flush_out_valid got %b want 0", ov[1]); end
    checks++; if (occ_of(1) != 0) begin errors++;
      $display("FAIL flush_occ got %0d want 0", occ_of(1)); end
    checks++; if (ir[1] !== 1'b1) begin errors++;
      $display("FAIL flush_in_ready got %b want 1", ir[1]); end
    for (int c = 0; c < 4; c++) begin
      checks++; if (ov[1] !== 1'b0) begin errors++;
        $display("FAIL flush_leak c%0d got %h want none", c, od[1]); end
      step(1, a, p);
    end
    pg = rnd_pay(555);
    for (int c = 0; c < 8; c++) begin
      iv[1] = (c == 0);
      id[1] = pg;
      if (ov[1]) begin
        seen++;
        checks++; if (od[1] !== pg) begin errors++;
          $display("FAIL flush_after got %h want %h", od[1], pg); end
      end
      step(1, a, p);
    end
    checks++; if (seen != 1) begin errors++;
      $display("FAIL flush_after_count got %0d want 1", seen); end
    idle_inputs();
  endtask

  task automatic test_gating();
    bit a, p;
    logic [DW-1:0] pp;
    logic [DW-1:0] pq;
    do_reset();
    pp = rnd_pay(7) | DW'(3);
    pq = rnd_pay(8) | DW'(3);
    ordy[0] = 1'b1;
    iv[0] = 1'b1; id[0] = pp;
    step(0, a, p);
    iv[0] = 1'b0;
    checks++; if (ov[0] !== 1'b1 || od[0] !== pp) begin errors++;
      $display("FAIL gate_valid got %b/%h want 1/%h", ov[0], od[0], pp); end
    step(0, a, p);
    checks++; if (ov[0] !== 1'b0 || od[0][1:0] !== 2'b00) begin errors++;
      $display("FAIL gate_ctrl got %b/%b want 0/00", ov[0], od[0][1:0]); end
    checks++; if (od[0][DW-1:2] !== pp[DW-1:2]) begin errors++;
      $display("FAIL gate_held got %h want %h", od[0][DW-1:2], pp[DW-1:2]); end
    iv[0] = 1'b1; id[0] = pq;
    step(0, a, p);
    iv[0] = 1'b0;
    checks++; if (ov[0] !== 1'b1 || od[0] !== pq) begin errors++;
      $display("FAIL gate_next got %b/%h want 1/%h", ov[0], od[0], pq); end
    step(0, a, p);
    idle_inputs();
  endtask

  task automatic test_random();
    bit a, p;
    int seq = 1;
    int bias;
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      if (c % 500 == 0) bias = $urandom_range(1, 3);
      iv[2]   = ($urandom_range(0, 3) < bias);
      ordy[2] = ($urandom_range(0, 3) >= bias - 1);
      fl[2]   = ($urandom_range(0, 499) == 0);
      id[2]   = rnd_pay(seq);
      checks++; if (occ_of(2) != sb.size()) begin errors++;
        $display("FAIL rand_occ c%0d got %0d want %0d", c, occ_of(2), sb.size()); end
      if (ov[2]) begin
        checks++;
        if (sb.size() == 0 || od[2] !== sb[0]) begin errors++;
          $display("FAIL rand_data c%0d got %h want %h", c, od[2], sb.size() ? sb[0] : '0); end
      end else begin
        checks++; if (od[2][1:0] !== 2'b00) begin errors++;
          $display("FAIL rand_gate c%0d got %b want 00", c, od[2][1:0]); end
      end
      step(2, a, p);
      if (p && sb.size() > 0) void'(sb.pop_front());
      if (a) begin sb.push_back(id[2]); seq++; end
      if (fl[2]) sb.delete();
    end
    idle_inputs();
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_gating();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_elastic.md
# pipe_stage_elastic

Parametrised elastic pipeline-stage register; successor to the fixed, always-enabled inter-stage registers between EX/MEM/WB. It carries an arbitrary-width payload through STAGES back-to-back register stages with a valid/ready handshake, a per-stage skid buffer for back-pressure, and a synchronous flush. When a slot is empty, its control bits are forced to zero so that a bubble never writes state downstream.

## Interface
- DATA_W, 71: payload width (e.g. PC_next 32 + ALU_result 32 + writeAddr 5 + RegWrite 1 + MemtoReg 1).
- CTRL_W, 2: payload bits [CTRL_W-1:0] are control bits, gated to 0 on the output when out_valid=0. Legal range 0..DATA_W.
- STAGES, 1: number of chained stages. Legal range ≥1.
- OCC_W, $clog2(2*STAGES+1): occupancy counter width.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  upstream has a payload.
- in_data  in  DATA_W  upstream payload.
- in_ready  out  1  block accepts this cycle; registered.
- out_valid  out  1  head payload valid.
- out_data  out  DATA_W  head payload; control bits gated.
- out_ready  in  1  downstream consumes this cycle.
- occupancy  out  OCC_W  number of valid entries held, 0..2*STAGES.

## Operation
- Each stage i holds two slots: main (m_valid, m_data) and skid (s_valid, s_data).
  - Stage input is the previous stage's main output, or in_* for stage 0.
  - Stage 0 in_ready = !s_valid[0].
  - Stage i ready toward i-1 = !s_valid[i].
- out_valid = m_valid[STAGES-1].
- out_data = m_data[STAGES-1], with bits [CTRL_W-1:0] ANDed with out_valid.
- Per stage, each edge, with acc = up_valid & !s_valid and pop = m_valid & dn_ready:
  - If !m_valid or pop:
    - If s_valid: m ← s and s_valid ← 0.
    - Else if acc: m ← up_data and m_valid ← 1.
    - Else: m_valid ← 0.
  - Else (main full, not popping):
    - If acc: s ← up_data and s_valid ← 1.
  - acc with s_valid=1 cannot occur, because ready is low.
- Data registers load only on the cases above. Otherwise they hold their value and are not cleared by a pop.
- occupancy = Σ(m_valid + s_valid) over all stages.
  - Maintained as a counter: +1 on an accept at stage 0, −1 on a pop at the last stage, unchanged when both occur in the same cycle.
  - Equals the popcount of all valid bits at all times.
- Flush:
  - All m_valid/s_valid ← 0 and occupancy ← 0.
  - An in_valid&in_ready handshake in the same cycle is discarded, and any out_valid&out_ready in that cycle still counts as consumed by downstream.
  - Flush has priority over all other updates.
- Reset: same effect as flush; additionally all data registers ← 0.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, occupancy=0.
- Latency: a payload accepted at edge k into an empty pipe with out_ready=1 presents out_valid=1 after edge k+STAGES-1, i.e. STAGES cycles after acceptance. For STAGES=1 it is visible the cycle after acceptance.
- Throughput: 1 payload per cycle when out_ready is held at 1; no bubbles are inserted.
- Capacity: 2*STAGES entries. in_ready falls the cycle after stage 0's skid fills.
- in_ready has no combinational path from in_valid or out_ready.
- out_ready deasserted: the head is held stable (out_valid and out_data unchanged) until consumed.
- Ordering: strict FIFO and no duplication, including across skid refill.
- in_valid may rise while in_ready=0; the payload is taken on the first cycle both are high.
- flush with rst both high: reset behaviour.
- flush and out_ready in the same cycle: out_valid=0 and occupancy=0 next cycle.

## Test plan
- Reset with STAGES=2 → in_ready=1, out_valid=0, out_data=0, occupancy=0.
- Stream 0x1..0x8, one per cycle, with out_ready=1 and STAGES=2 → out_data shows 0x1..0x8 on consecutive cycles, the first one 2 cycles after its acceptance; occupancy stays ≤2.
- STAGES=1, out_ready=0, drive 3 payloads:
  - A and B accepted, then in_ready=0 and C stalls; occupancy=2.
  - Raise out_ready → outputs A, B, C in order, C accepted the cycle after A pops.
- Fill STAGES=2 to occupancy=4, then pulse flush with in_valid=1 → occupancy=0 and out_valid=0 next cycle, the concurrent input is not output, and in_ready=1.
- Empty pipe, CTRL_W=2, held data 0x...3 from the last payload → out_data[1:0]=0 while out_valid=0, and the full value appears when the next payload is valid.
- Random in_valid/out_ready over 10k cycles with STAGES=3 → the scoreboard sees in-order, lossless, non-duplicated delivery, and occupancy matches the model every cycle.
